// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Single-clock FIFO with configurable width and power-of-two
//               depth, a registered read-valid strobe, an occupancy count and
//               almost-full/almost-empty watermarks. Defining the macro
//               FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags with
//               an err_clr input.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    write_en,
   input  logic                    read_en,
   input  logic [DATA_WIDTH-1:0]   data_in,
`ifdef FIFO_ERR_FLAGS_EN
   input  logic                    err_clr,
   output logic                    overflow,
   output logic                    underflow,
`endif
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    data_valid,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;
   localparam logic [c_CW-1:0] c_DEPTH  = c_CW'(DEPTH);
   localparam logic [c_CW-1:0] c_AF_THR = c_CW'(AF_THRESH);
   localparam logic [c_CW-1:0] c_AE_THR = c_CW'(AE_THRESH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]       r_wr_ptr;
   logic [c_AW-1:0]       r_rd_ptr;
   logic [c_CW-1:0]       r_count;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_data_valid;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_almost_full;
   logic                  r_almost_empty;

   logic                  w_rd_ok;
   logic                  w_wr_ok;
   logic [c_CW-1:0]       w_count_nxt;

   // A read frees a slot in the same cycle, so a write at full is accepted alongside it.
   assign w_rd_ok     = read_en && !r_empty;
   assign w_wr_ok     = write_en && (!r_full || w_rd_ok);
   assign w_count_nxt = r_count + c_CW'(w_wr_ok) - c_CW'(w_rd_ok);

   always_ff @(posedge clk) begin
      if (w_wr_ok && !rst) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_data_out     <= '0;
         r_data_valid   <= 1'b0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_ok) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_data_out <= r_mem[r_rd_ptr];
         end
         r_data_valid   <= w_rd_ok;
         r_count        <= w_count_nxt;
         // Flags track the next-state count so they never lag count by a cycle.
         r_full         <= (w_count_nxt == c_DEPTH);
         r_empty        <= (w_count_nxt == '0);
         r_almost_full  <= (w_count_nxt >= c_AF_THR);
         r_almost_empty <= (w_count_nxt <= c_AE_THR);
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;
   logic w_ovf_evt;
   logic w_unf_evt;

   assign w_ovf_evt = write_en && !w_wr_ok;
   assign w_unf_evt = read_en && r_empty;

   // A new error in the clearing cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= (r_overflow && !err_clr) || w_ovf_evt;
         r_underflow <= (r_underflow && !err_clr) || w_unf_evt;
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`endif

   assign data_out     = r_data_out;
   assign data_valid   = r_data_valid;
   assign full         = r_full;
   assign empty        = r_empty;
   assign almost_full  = r_almost_full;
   assign almost_empty = r_almost_empty;
   assign count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Directed scoreboard bench for sync_fifo_param (8 x 8 config).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

   localparam int c_DW    = 8;
   localparam int c_DEPTH = 8;
   localparam int c_AF    = 6;
   localparam int c_AE    = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             write_en = 1'b0;
   logic             read_en = 1'b0;
   logic [c_DW-1:0]  data_in = '0;
   logic [c_DW-1:0]  data_out;
   logic             data_valid;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [3:0]       count;
`ifdef FIFO_ERR_FLAGS_EN
   logic             err_clr = 1'b0;
   logic             overflow;
   logic             underflow;
`endif

   sync_fifo_param #(
      .DATA_WIDTH (c_DW),
      .DEPTH      (c_DEPTH),
      .AF_THRESH  (c_AF),
      .AE_THRESH  (c_AE)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .write_en     (write_en),
      .read_en      (read_en),
      .data_in      (data_in),
`ifdef FIFO_ERR_FLAGS_EN
      .err_clr      (err_clr),
      .overflow     (overflow),
      .underflow    (underflow),
`endif
      .data_out     (data_out),
      .data_valid   (data_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [c_DW-1:0] q_model[$];
   logic [c_DW-1:0] q_exp[$];
   int              m_count = 0;
   logic [c_DW-1:0] m_last_out = '0;
   logic            m_ovf = 1'b0;
   logic            m_unf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, predict, then sample 1 ns after the edge.
   task automatic step(input logic we, input logic re, input logic [c_DW-1:0] din,
                       input logic rs, input logic ec);
      logic            rd_ok;
      logic            wr_ok;
      logic [c_DW-1:0] exp_d;
      write_en = we;
      read_en  = re;
      data_in  = din;
      rst      = rs;
`ifdef FIFO_ERR_FLAGS_EN
      err_clr  = ec;
`endif
      rd_ok = re && (m_count != 0);
      wr_ok = we && ((m_count != c_DEPTH) || rd_ok);
      if (rs) begin
         q_model.delete();
         q_exp.delete();
         m_count    = 0;
         m_last_out = '0;
         m_ovf      = 1'b0;
         m_unf      = 1'b0;
         rd_ok      = 1'b0;
      end else begin
         m_ovf = (m_ovf && !ec) || (we && !wr_ok);
         m_unf = (m_unf && !ec) || (re && (m_count == 0));
         if (rd_ok) q_exp.push_back(q_model.pop_front());
         if (wr_ok) q_model.push_back(din);
         m_count = m_count + int'(wr_ok) - int'(rd_ok);
      end
      @(posedge clk);
      #1;
      chk("count", 32'(count), 32'(m_count));
      chk("empty", 32'(empty), 32'(m_count == 0));
      chk("full", 32'(full), 32'(m_count == c_DEPTH));
      chk("almost_full", 32'(almost_full), 32'(m_count >= c_AF));
      chk("almost_empty", 32'(almost_empty), 32'(m_count <= c_AE));
      chk("data_valid", 32'(data_valid), 32'(rd_ok));
      if (rd_ok) begin
         exp_d      = q_exp.pop_front();
         m_last_out = exp_d;
         chk("data_out", 32'(data_out), 32'(exp_d));
      end else begin
         chk("data_out_hold", 32'(data_out), 32'(m_last_out));
      end
`ifdef FIFO_ERR_FLAGS_EN
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
`endif
      rst = 1'b0;
   endtask

   initial begin
      // Reset state
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);

      // Single write then read
      step(1'b1, 1'b0, 8'h05, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Fill, reject ninth write, drain in order
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

      // Simultaneous read/write at full
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

      // Read at empty, clear error, read+write at empty
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

      // Wrap-around streaming at occupancy 1
      step(1'b1, 1'b0, 8'h40, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

      // Reset mid-operation with a pending write
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the next-generation buffer for the datapath. It generalises the fixed 8-bit FIFO to any width and any power-of-two depth. New over the previous generation: concurrent read/write at full, a registered read-valid strobe, an occupancy count and programmable almost-full/almost-empty watermarks. Optional sticky overflow/underflow error flags are available at build time.

## Interface
- `DATA_WIDTH`, 8, data word width in bits (≥1)
- `DEPTH`, 16, number of entries; power of two, ≥2
- `AF_THRESH`, DEPTH-2, `almost_full` asserts when count ≥ AF_THRESH (1..DEPTH)
- `AE_THRESH`, 2, `almost_empty` asserts when count ≤ AE_THRESH (0..DEPTH-1)
- `clk` in 1, single clock, all logic on rising edge
- `rst` in 1, synchronous, active-high reset
- `write_en` in 1, write request
- `read_en` in 1, read request
- `data_in` in DATA_WIDTH, write data, sampled with `write_en`
- `data_out` out DATA_WIDTH, registered read data
- `data_valid` out 1, one-cycle strobe: `data_out` updated by an accepted read
- `full` out 1, count == DEPTH
- `empty` out 1, count == 0
- `almost_full` out 1, count ≥ AF_THRESH
- `almost_empty` out 1, count ≤ AE_THRESH
- `count` out $clog2(DEPTH)+1, current occupancy 0..DEPTH
- `err_clr` in 1, clears error flags (present only with FIFO_ERR_FLAGS_EN)
- `overflow` out 1, sticky: write rejected (present only with FIFO_ERR_FLAGS_EN)
- `underflow` out 1, sticky: read rejected (present only with FIFO_ERR_FLAGS_EN)

## Operation
- Read and write acceptance:
  - rd_ok = `read_en` && !`empty`.
  - wr_ok = `write_en` && (!`full` || rd_ok). At full, a simultaneous read and write are both accepted; count stays at DEPTH.
  - At empty, a simultaneous read and write: the read is rejected and the write is accepted. No fall-through.
- Storage:
  - Circular RAM of DEPTH × DATA_WIDTH.
  - Write and read pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
  - RAM contents are not reset.
- Count update: count += wr_ok − rd_ok. It never exceeds DEPTH and never goes below 0.
- Read data:
  - On rd_ok, `data_out` ← mem[rd_ptr] and `data_valid` = 1 for one cycle.
  - Otherwise `data_out` holds its last value and `data_valid` = 0.
- Flags: all flags are registered and derived from the next-state count, so they are consistent with `count` on every cycle.
- Rejected requests leave all state unchanged. With FIFO_ERR_FLAGS_EN they also set an error flag.
- Reset values (rst dominates any simultaneous request):
  - `data_out`=0, `data_valid`=0, `count`=0
  - `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0
  - `overflow`=0, `underflow`=0
  - Both pointers = 0.
- Reset asserted mid-operation discards all stored entries at that edge.

## Timing
- Write at edge N: `count`, `empty`, `full` and watermarks reflect it after edge N.
- Read sampled at edge N: `data_out` and `data_valid` are valid after edge N (1-cycle read latency).
- Minimum write-to-read-data latency is 2 edges. A write at edge N clears `empty`; the read is sampled at edge N+1; data appears after edge N+1.
- Sustained throughput is one write and one read per cycle, including at full.
- No combinational path from inputs to outputs.

## Configuration
- Macro: `FIFO_ERR_FLAGS_EN`.
- With `FIFO_ERR_FLAGS_EN` defined:
  - `overflow` sets on any cycle with `write_en` && !wr_ok.
  - `underflow` sets on any cycle with `read_en` && `empty`.
  - Both are sticky until `err_clr` or `rst`.
  - If `err_clr` and a new error occur in the same cycle, set wins.
- Without it: ports `err_clr`, `overflow` and `underflow` are absent, and rejected requests are silently dropped.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2.
- Reset then write 8'h05: `empty` 1→0 after the write edge, `count`=1. Read next cycle: `data_out`=8'h05, `data_valid`=1 for one cycle, `empty`=1, `count`=0.
- Write 8 words 8'h10..8'h17: `almost_full` rises at count 6 and `full` at count 8. A 9th write (8'hFF) is rejected, count stays 8, and `overflow`=1 when enabled. Draining 8 reads returns 8'h10..8'h17 in order.
- Fill to full, then assert `read_en` and `write_en` (8'hAA) together for 1 cycle: `count` stays 8, `full` stays 1, `data_out`=oldest entry, and 8'hAA is the last word read on drain.
- Read while empty: `data_valid`=0, `data_out` unchanged, and `underflow`=1 when enabled. Pulse `err_clr` → `underflow`=0. Simultaneous read+write at empty: count becomes 1, `data_valid`=0.
- Wrap-around: 20 cycles of continuous simultaneous write/read with an incrementing pattern after 1 pre-load. Output stream matches the input delayed by one entry, and `count` stays 1 throughout.
- Assert `rst` with count=5 while `write_en` is high: after the edge, `count`=0, `empty`=1, `almost_empty`=1, `data_valid`=0. The next read is rejected.
